hsstl_rx_rst_ctrl_nlane_v2_0: RTL
=================================

// Module: hsstl_rx_rst_ctrl_nlane_v2_0
// PURPOSE
//  Parametrised N-lane HSST RX reset/bring-up controller for the PCIe PIPE wrapper.
//  Sequences PMA/PCS/CB resets per lane, debounces LOS/CDR/word-align status and
//  masks unused lanes for narrow links. Supports three line rates with a
//  recovery-gated rate-change FSM. Sits between the LTSSM/PIPE logic and the HSST lane ports.
// PARAMETERS
//  LANES        4     number of RX lanes (1..8)
//  LOS_DEB      4     clk cycles LOS must stay clear before it is taken as clear
//  CDR_DEB      2048  clk cycles CDR_ALIGN must stay high before it is taken as locked
//  WA_DEB       1024  clk cycles LSM_SYNCED must stay high (only with HSST_RX_WA_DEB_EN)
//  PMA_RST_CYC  16    PMA reset pulse width, in cycles
//  RATE_WAIT    64    cycles after the rate update before PMA reset is released
//  CNTR_W       12    debounce/wait counter width; must be >= clog2 of the largest count
// PORTS
//  clk                 in   1        lane-ref user clock; the only clock
//  rst                 in   1        synchronous, active-high reset
//  rxlane_soft_rst     in   LANES    per-lane soft reset, active high, level
//  lane_en             in   LANES    active-lane mask; sampled only in M_IDLE
//  tx_rst_done         in   1        TX bring-up complete
//  ltssm_in_recovery   in   1        rate change permitted only while high
//  rate                in   2        0=2.5G, 1=5G, 2=8G, 3=reserved (treated as 2)
//  P_LX_ALOS_STA       in   LANES    async loss-of-signal, 1 = no signal
//  P_LX_CDR_ALIGN      in   LANES    async CDR lock
//  P_PCS_LSM_SYNCED    in   LANES    async word-align sync
//  P_PMA_RX_PD         out  LANES    PMA power-down
//  P_PMA_RX_RST        out  LANES    PMA reset
//  P_PCS_RX_RST        out  LANES    PCS reset
//  P_PCS_CB_RST        out  LANES    channel-bond reset
//  P_LX_RX_RATE        out  3*LANES  per-lane rate code, lane i at [3i+2:3i]
//  rx_main_fsm         out  3        main FSM state
//  lane_fsm            out  3*LANES  lane FSM states
//  init_done           out  LANES    lane reached L_READY
//  hsst_ch_ready       out  LANES    init_done AND main FSM in M_READY
//  rate_done           out  1        one-cycle pulse when a rate change completes
// BEHAVIOUR
//  Reset values: PD=all 1, PMA/PCS/CB_RST=all 1, RX_RATE=3'd2 per lane,
//    FSMs=0, init_done/ch_ready/rate_done=0.
//  Status inputs: 2-FF synchronisers, then rise debounce. Rising edge is accepted
//    after the N-cycle stable count; falling edge is passed on the next cycle.
//    A glitch before the count completes clears the counter to 0.
//  Lane FSM (3b): L_IDLE0 > L_PMA_RST1 (PMA_RST_CYC cycles) > L_WAIT_LOS2 >
//    L_WAIT_CDR3 > L_PCS_RST4 (1 cycle, releases PCS) > L_WAIT_SYNC5 > L_READY6.
//    PCS_RST is held 1 in states 0..3. PMA_RST is held 1 in states 0..1.
//  Lane exceptions (next cycle): LOS asserted in states >=3 -> L_WAIT_LOS, PCS_RST=1.
//    CDR lost in states >=4 -> L_WAIT_CDR.
//    rxlane_soft_rst in any state -> L_PMA_RST. This one has priority over LOS and CDR.
//  CB reset: released on all enabled lanes in the same cycle, once every enabled
//    lane is at state >= 4. Re-asserted on all enabled lanes when any enabled lane
//    falls below state 4.
//  Masked lane (lane_en=0): PD=1, all resets=1, held in L_IDLE, init_done=0.
//    Masked lanes are excluded from every all-lanes condition.
//  Main FSM (3b): M_IDLE0 (PD=1; wait tx_rst_done, latch lane_en) > M_INIT1
//    (PD=0 on enabled lanes; lanes run) > M_READY2 (all enabled init_done).
//  Rate change: rate != current while ltssm_in_recovery=1 latches a request.
//    The request is serviced only from M_READY: M_RATE_RST3 (PMA_RST=1 on enabled
//    lanes for PMA_RST_CYC cycles, lanes forced to L_WAIT_CDR) > M_RATE_SET4
//    (RX_RATE updates, wait RATE_WAIT cycles) > M_INIT. rate_done pulses on re-entry to M_READY.
//    A rate change requested outside recovery is ignored.
//    A request made during M_INIT is deferred until M_READY.
//    A new rate value arriving during M_RATE_* overwrites the latch and is serviced
//    on the next M_READY.
//  Same-cycle rate request and LOS: the rate sequence proceeds; LOS is handled
//    on re-entry to M_INIT.
//  lane_en == 0 -> stays in M_IDLE, no outputs change.
//  tx_rst_done falling in any state -> M_IDLE next cycle, all outputs return to reset values.
// CONFIGURATION
//  HSST_RX_WA_DEB_EN defined: LSM_SYNCED needs WA_DEB stable cycles before L_READY.
//  HSST_RX_WA_DEB_EN undefined: synchronised LSM_SYNCED is used directly, no counter
//    is instantiated, and L_WAIT_SYNC -> L_READY follows the synced input 1 cycle later.
// TESTING
//  T1 LANES=4, lane_en=F, all status good, tx_rst_done=1 -> ch_ready=F; with WA_DEB
//     enabled, reached about 2048+1024+16+small overhead cycles after tx_rst_done.
//  T2 lane_en=1 -> PD=4'b1110; RST[3:1] stay 1; ch_ready=4'b0001.
//  T3 CDR 1-cycle drop at count 2000 -> counter restarts; lock asserted 2048 cycles after the glitch.
//  T4 READY, recovery=1, rate 0->1 -> PMA_RST=F for 16 cycles, RX_RATE=3'd1 per lane,
//     rate_done one pulse, ch_ready=F again.
//  T5 rate 0->2 with recovery=0 -> no state change; RX_RATE stays 3'd2.
//  T6 lane2 LOS in READY -> lane2 in L_WAIT_LOS, CB_RST=F on all lanes, recovery after LOS clears.

Source files
------------

// File: rtl/hsstl_rx_rst_ctrl_nlane_v2_0.sv
// N-lane HSST RX reset/bring-up controller: per-lane PMA/PCS/CB reset sequencing,
// status debounce, lane masking and recovery-gated rate change. Optional macro: HSST_RX_WA_DEB_EN.

module hsstl_rx_deb #(
  parameter int N = 4,
  parameter int W = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic stable
);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_reg;
  logic         stable_reg;

  // Rise is accepted after N consecutive high samples; any low sample drops it at once.
  always_ff @(posedge clk) begin
    if (rst || !level) begin
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
    end else if (cnt_reg == LAST) begin
      stable_reg <= 1'b1;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign stable = stable_reg;
endmodule

module hsstl_rx_rst_ctrl_nlane_v2_0 #(
  parameter int LANES       = 4,
  parameter int LOS_DEB     = 4,
  parameter int CDR_DEB     = 2048,
  parameter int WA_DEB      = 1024,
  parameter int PMA_RST_CYC = 16,
  parameter int RATE_WAIT   = 64,
  parameter int CNTR_W      = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LANES-1:0]     rxlane_soft_rst,
  input  logic [LANES-1:0]     lane_en,
  input  logic                 tx_rst_done,
  input  logic                 ltssm_in_recovery,
  input  logic [1:0]           rate,
  input  logic [LANES-1:0]     P_LX_ALOS_STA,
  input  logic [LANES-1:0]     P_LX_CDR_ALIGN,
  input  logic [LANES-1:0]     P_PCS_LSM_SYNCED,
  output logic [LANES-1:0]     P_PMA_RX_PD,
  output logic [LANES-1:0]     P_PMA_RX_RST,
  output logic [LANES-1:0]     P_PCS_RX_RST,
  output logic [LANES-1:0]     P_PCS_CB_RST,
  output logic [3*LANES-1:0]   P_LX_RX_RATE,
  output logic [2:0]           rx_main_fsm,
  output logic [3*LANES-1:0]   lane_fsm,
  output logic [LANES-1:0]     init_done,
  output logic [LANES-1:0]     hsst_ch_ready,
  output logic                 rate_done
);
  localparam logic [2:0] M_IDLE = 3'd0, M_INIT = 3'd1, M_READY = 3'd2,
                         M_RATE_RST = 3'd3, M_RATE_SET = 3'd4;
  localparam logic [2:0] L_IDLE = 3'd0, L_PMA_RST = 3'd1, L_WAIT_LOS = 3'd2, L_WAIT_CDR = 3'd3,
                         L_PCS_RST = 3'd4, L_WAIT_SYNC = 3'd5, L_READY = 3'd6;
  localparam logic [CNTR_W-1:0] PMA_LAST  = CNTR_W'(PMA_RST_CYC - 1);
  localparam logic [CNTR_W-1:0] RATE_LAST = CNTR_W'(RATE_WAIT - 1);

  logic [2:0]        main_reg;
  logic [CNTR_W-1:0] main_cnt_reg;
  logic [LANES-1:0]  en_reg;
  logic [1:0]        cur_rate_reg, req_rate_reg;
  logic              req_valid_reg, rate_active_reg, rate_done_reg;
  logic [LANES-1:0]  lane_ready, lane_ge4;
  logic [1:0]        rate_eff, rate_target;
  logic              all_ready, all_ge4, lanes_run, lanes_hold;

  assign rate_eff    = (rate == 2'd3) ? 2'd2 : rate;
  // Compare against the pending request so a serviced value is not latched twice.
  assign rate_target = req_valid_reg ? req_rate_reg : cur_rate_reg;
  assign all_ready   = &(lane_ready | ~en_reg);
  assign all_ge4     = &(lane_ge4 | ~en_reg);
  assign lanes_run   = (main_reg == M_INIT) || (main_reg == M_READY);
  assign lanes_hold  = (main_reg == M_RATE_RST) || (main_reg == M_RATE_SET);

  always_ff @(posedge clk) begin
    if (rst || !tx_rst_done) begin
      main_reg        <= M_IDLE;
      main_cnt_reg    <= '0;
      en_reg          <= '0;
      cur_rate_reg    <= 2'd2;
      req_rate_reg    <= 2'd2;
      req_valid_reg   <= 1'b0;
      rate_active_reg <= 1'b0;
      rate_done_reg   <= 1'b0;
    end else begin
      rate_done_reg <= 1'b0;
      case (main_reg)
        M_IDLE: if (|lane_en) begin
          en_reg   <= lane_en;
          main_reg <= M_INIT;
        end
        M_INIT: if (all_ready) begin
          main_reg        <= M_READY;
          rate_done_reg   <= rate_active_reg;
          rate_active_reg <= 1'b0;
        end
        M_READY: if (req_valid_reg) begin
          main_reg        <= M_RATE_RST;
          main_cnt_reg    <= '0;
          rate_active_reg <= 1'b1;
        end else if (!all_ready) begin
          main_reg <= M_INIT;
        end
        M_RATE_RST: if (main_cnt_reg == PMA_LAST) begin
          main_reg      <= M_RATE_SET;
          main_cnt_reg  <= '0;
          cur_rate_reg  <= req_rate_reg;
          req_valid_reg <= 1'b0;
        end else begin
          main_cnt_reg <= main_cnt_reg + 1'b1;
        end
        M_RATE_SET: if (main_cnt_reg == RATE_LAST) main_reg <= M_INIT;
                    else main_cnt_reg <= main_cnt_reg + 1'b1;
        default: main_reg <= M_IDLE;
      endcase
      if (ltssm_in_recovery && (rate_eff != rate_target)) begin
        req_valid_reg <= 1'b1;
        req_rate_reg  <= rate_eff;
      end
    end
  end

  genvar gi;
  for (gi = 0; gi < LANES; gi++) begin : g_lane
    logic [2:0]        meta_reg, sync_reg;
    logic              los_clear, cdr_lock, wa_ok;
    logic [2:0]        st_reg;
    logic [CNTR_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        meta_reg <= '0;
        sync_reg <= '0;
      end else begin
        meta_reg <= {P_PCS_LSM_SYNCED[gi], P_LX_CDR_ALIGN[gi], ~P_LX_ALOS_STA[gi]};
        sync_reg <= meta_reg;
      end
    end

    hsstl_rx_deb #(.N(LOS_DEB), .W(CNTR_W)) u_los_deb (
      .clk(clk), .rst(rst), .level(sync_reg[0]), .stable(los_clear));
    hsstl_rx_deb #(.N(CDR_DEB), .W(CNTR_W)) u_cdr_deb (
      .clk(clk), .rst(rst), .level(sync_reg[1]), .stable(cdr_lock));
`ifdef HSST_RX_WA_DEB_EN
    hsstl_rx_deb #(.N(WA_DEB), .W(CNTR_W)) u_wa_deb (
      .clk(clk), .rst(rst), .level(sync_reg[2]), .stable(wa_ok));
`else
    assign wa_ok = sync_reg[2];
`endif

    // Soft reset outranks LOS, LOS outranks CDR loss; the rate sequence outranks all.
    always_ff @(posedge clk) begin
      if (rst || !tx_rst_done || !en_reg[gi] || !(lanes_run || lanes_hold)) begin
        st_reg  <= L_IDLE;
        cnt_reg <= '0;
      end else if (lanes_hold) begin
        st_reg  <= L_WAIT_CDR;
        cnt_reg <= '0;
      end else if (rxlane_soft_rst[gi]) begin
        st_reg  <= L_PMA_RST;
        cnt_reg <= '0;
      end else if ((st_reg >= L_WAIT_CDR) && !los_clear) begin
        st_reg <= L_WAIT_LOS;
      end else if ((st_reg >= L_PCS_RST) && !cdr_lock) begin
        st_reg <= L_WAIT_CDR;
      end else begin
        case (st_reg)
          L_IDLE: begin
            st_reg  <= L_PMA_RST;
            cnt_reg <= '0;
          end
          L_PMA_RST: if (cnt_reg == PMA_LAST) st_reg <= L_WAIT_LOS;
                     else cnt_reg <= cnt_reg + 1'b1;
          L_WAIT_LOS:  if (los_clear) st_reg <= L_WAIT_CDR;
          L_WAIT_CDR:  if (cdr_lock) st_reg <= L_PCS_RST;
          L_PCS_RST:   st_reg <= L_WAIT_SYNC;
          L_WAIT_SYNC: if (wa_ok) st_reg <= L_READY;
          L_READY:     st_reg <= L_READY;
          default:     st_reg <= L_IDLE;
        endcase
      end
    end

    assign lane_ready[gi]           = (st_reg == L_READY);
    assign lane_ge4[gi]             = (st_reg >= L_PCS_RST);
    assign lane_fsm[3*gi +: 3]      = st_reg;
    assign P_LX_RX_RATE[3*gi +: 3]  = {1'b0, cur_rate_reg};
    assign P_PMA_RX_PD[gi]          = !(en_reg[gi] && (main_reg != M_IDLE));
    assign P_PMA_RX_RST[gi]         = (st_reg <= L_PMA_RST) || (en_reg[gi] && (main_reg == M_RATE_RST));
    assign P_PCS_RX_RST[gi]         = (st_reg < L_PCS_RST) || lanes_hold;
    assign P_PCS_CB_RST[gi]         = !(en_reg[gi] && lanes_run && all_ge4);
    assign init_done[gi]            = en_reg[gi] && (st_reg == L_READY);
    assign hsst_ch_ready[gi]        = en_reg[gi] && (st_reg == L_READY) && (main_reg == M_READY);
  end

  assign rx_main_fsm = main_reg;
  assign rate_done   = rate_done_reg;
endmodule
